serdes_64b66b_tx_gearbox: RTL

- TX 66b-to-64b gearbox and TX sequence-counter owner for the 64B/66B PCS.
- Drives a free-running 0–32 sequence counter to the upstream encoder and scrambler path.
- Consumes the scrambler's registered data, header and sequence outputs.
- Packs 32 66-bit blocks into 33 64-bit words for the serdes parallel TX interface.
- Detects sequence discontinuities and resynchronises on sequence 0.

---
 rtl/serdes_64b66b_tx_gearbox.sv | 106 ++++++++++
 1 files changed

// File: rtl/serdes_64b66b_tx_gearbox.sv
// TX 66b->64b gearbox: packs 32 sequenced 66-bit blocks into 33 64-bit serdes words and owns the TX sequence counter.
// Latency 1 cycle input to O_tx_gb_data; no backpressure, runs every cycle and resyncs on sequence 0.
module serdes_64b66b_tx_gearbox #(
  parameter int C_TX_DATA_WIDTH = 64,
  parameter int C_ERR_CNT_WIDTH = 16
) (
  input  logic                       I_pcs_tx_clk,
  input  logic                       I_pcs_tx_rst_n,
  output logic [5:0]                 O_tx_seq,
  input  logic [C_TX_DATA_WIDTH-1:0] I_tx_data,
  input  logic [1:0]                 I_tx_header,
  input  logic [5:0]                 I_tx_seq,
  output logic [C_TX_DATA_WIDTH-1:0] O_tx_gb_data,
  output logic                       O_tx_gb_locked,
  output logic                       O_tx_seq_err,
  output logic [C_ERR_CNT_WIDTH-1:0] O_tx_seq_err_cnt
);

  typedef enum logic {SYNC_WAIT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [C_TX_DATA_WIDTH-1:0]   leftover_q, leftover_d;
  logic [C_TX_DATA_WIDTH-1:0]   gb_data_q, gb_data_d;
  logic [C_TX_DATA_WIDTH-1:0]   lo;
  logic [C_ERR_CNT_WIDTH-1:0]   err_cnt_q;
  logic [5:0]                   seq_cnt_q, prev_seq_q, exp_seq;
  logic [6:0]                   sh_h, sh_d;
  logic                         seq_err_q, seq_err_d, do_pack;

  always_comb begin
    state_d    = state_q;
    leftover_d = leftover_q;
    gb_data_d  = '0;
    seq_err_d  = 1'b0;
    do_pack    = 1'b0;
    lo         = '0;
    exp_seq    = (prev_seq_q == 6'd32) ? 6'd0 : prev_seq_q + 6'd1;
    sh_h       = {I_tx_seq, 1'b0};
    sh_d       = sh_h + 7'd2;

    case (state_q)
      SYNC_WAIT: begin
        leftover_d = '0;
        if (I_tx_seq == 6'd0) begin
          state_d = LOCKED;
          do_pack = 1'b1;
        end
      end
      LOCKED: begin
        if (I_tx_seq != exp_seq || I_tx_seq > 6'd32) begin
          seq_err_d = 1'b1;
          if (I_tx_seq == 6'd0) begin
            do_pack = 1'b1;
          end else begin
            state_d    = SYNC_WAIT;
            leftover_d = '0;
          end
        end else begin
          do_pack = 1'b1;
        end
      end
      default: state_d = SYNC_WAIT;
    endcase

    if (do_pack) begin
      if (I_tx_seq == 6'd32) begin
        gb_data_d  = leftover_q;
        leftover_d = '0;
      end else begin
        // Seq 0 always starts from an empty leftover, which also covers the
        // resync-on-zero case without a separate clear.
        lo         = (I_tx_seq == 6'd0) ? '0 : leftover_q;
        gb_data_d  = lo | (C_TX_DATA_WIDTH'(I_tx_header) << sh_h) | (I_tx_data << sh_d);
        leftover_d = I_tx_data >> (7'd62 - sh_h);
      end
    end
  end

  always_ff @(posedge I_pcs_tx_clk) begin
    if (!I_pcs_tx_rst_n) begin
      state_q    <= SYNC_WAIT;
      leftover_q <= '0;
      gb_data_q  <= '0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      seq_cnt_q  <= '0;
      prev_seq_q <= '0;
    end else begin
      state_q    <= state_d;
      leftover_q <= leftover_d;
      gb_data_q  <= gb_data_d;
      seq_err_q  <= seq_err_d;
      prev_seq_q <= I_tx_seq;
      seq_cnt_q  <= (seq_cnt_q == 6'd32) ? 6'd0 : seq_cnt_q + 6'd1;
      if (seq_err_d && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + {{(C_ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign O_tx_seq         = seq_cnt_q;
  assign O_tx_gb_data     = gb_data_q;
  assign O_tx_gb_locked   = (state_q == LOCKED);
  assign O_tx_seq_err     = seq_err_q;
  assign O_tx_seq_err_cnt = err_cnt_q;

endmodule
